param_block_pipe: RTL

- Parametrised successor of the fixed 3-stage 32-bit valid/ready compute pipeline: stage1 register, stage2 add-constant with multi-cycle multiply hold, stage3 multiply-constant output register.
- Adds: configurable width, constants and stage2 latency; optional input skid buffer so ready_o is driven from a register; synchronous flush; occupancy and busy status.
- Sits between any valid/ready producer and consumer in the CBB pipe library.

---
 rtl/param_block_pipe_pkg.sv | 31 +++
 rtl/pipe_skid_buf.sv | 42 ++++
 rtl/param_block_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/param_block_pipe_pkg.sv
// Shared constants and wrap-around arithmetic helpers for param_block_pipe.
package param_block_pipe_pkg;

    localparam int CNT_W = 4;
    localparam int OCC_W = 3;
    // Widest data path the helpers handle; DATA_W must not exceed this.
    localparam int MAX_W = 64;

    // Keep only the low w bits of v.
    function automatic logic [MAX_W-1:0] trunc_w(input logic [MAX_W-1:0] v,
                                                 input int unsigned     w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return v & mask;
    endfunction

    // a + b, wrapped modulo 2^w.
    function automatic logic [MAX_W-1:0] add_trunc(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input int unsigned     w);
        return trunc_w(a + b, w);
    endfunction

    // a * b, wrapped modulo 2^w.
    function automatic logic [MAX_W-1:0] mul_trunc(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input int unsigned     w);
        return trunc_w(a * b, w);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry input skid buffer: upstream ready comes straight from the full flag,
// so it never depends combinationally on downstream ready.
module pipe_skid_buf #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    output logic              full_o
);

    logic              full;
    logic [DATA_W-1:0] buf_q;

    assign ready_o = !full;
    assign full_o  = full;
    // A buffered word always goes first; while full, upstream is held off.
    assign valid_o = full || valid_i;
    assign data_o  = full ? buf_q : data_i;

    // Park the incoming word when downstream stalls; release once it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            buf_q <= '0;
        end else if (flush_i) begin
            full <= 1'b0;
        end else if (full) begin
            if (ready_i) full <= 1'b0;
        end else if (valid_i && !ready_i) begin
            full  <= 1'b1;
            buf_q <= data_i;
        end
    end

endmodule

// File: rtl/param_block_pipe.sv
// Three-stage valid/ready compute pipe: register, add constant with a
// multi-cycle hold, multiply constant into the output register.
module param_block_pipe
    import param_block_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int          ADD_C   = 4,
    parameter int          MUL_C   = 5,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned SKID    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    output logic [OCC_W-1:0]  occupancy_o,
    output logic              busy_o
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              skid_full;

    logic              s1_valid, s2_valid, s3_valid;
    logic [DATA_W-1:0] s1_data, s2_data, s3_data;
    logic [CNT_W-1:0]  s2_cnt;

    logic              s1_ready, s2_ready, s3_ready, s2_done;
    logic              s1_load, s2_load, s3_load;
    logic [DATA_W-1:0] s2_next, s3_next;

    assign s2_done  = (s2_cnt == CNT_W'(MUL_LAT));
    assign s3_ready = !s3_valid || ready_i;
    assign s2_ready = !s2_valid || (s2_done && s3_ready);
    assign s1_ready = !s1_valid || s2_ready;

    // Flush overrides every transfer, so no stage loads in a flush cycle.
    assign s1_load = in_valid && s1_ready && !flush_i;
    assign s2_load = s1_valid && s2_ready && !flush_i;
    assign s3_load = s2_valid && s2_done && s3_ready && !flush_i;

    assign s2_next = DATA_W'(add_trunc(MAX_W'(s1_data), MAX_W'(ADD_C), DATA_W));
    assign s3_next = DATA_W'(mul_trunc(MAX_W'(s2_data), MAX_W'(MUL_C), DATA_W));

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .flush_i (flush_i),
                .valid_i (valid_i),
                .data_i  (data_i),
                .ready_o (ready_o),
                .valid_o (in_valid),
                .data_o  (in_data),
                .ready_i (s1_ready),
                .full_o  (skid_full)
            );
        end else begin : g_noskid
            assign in_valid  = valid_i;
            assign in_data   = data_i;
            assign ready_o   = s1_ready;
            assign skid_full = 1'b0;
        end
    endgenerate

    // Stage1: plain capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage2: add constant, then hold until the counter reaches MUL_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_cnt   <= '0;
        end else if (flush_i) begin
            s2_valid <= 1'b0;
            s2_cnt   <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_data  <= s2_next;
            s2_cnt   <= '0;
        end else if (s3_load) begin
            s2_valid <= 1'b0;
        end else if (s2_valid && !s2_done) begin
            s2_cnt <= s2_cnt + CNT_W'(1);
        end
    end

    // Stage3: multiply constant into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
        end else if (flush_i) begin
            s3_valid <= 1'b0;
        end else if (s3_load) begin
            s3_valid <= 1'b1;
            s3_data  <= s3_next;
        end else if (ready_i) begin
            s3_valid <= 1'b0;
        end
    end

    assign valid_o     = s3_valid;
    assign data_o      = s3_data;
    assign busy_o      = s2_valid && !s2_done;
    assign occupancy_o = OCC_W'(skid_full) + OCC_W'(s1_valid)
                       + OCC_W'(s2_valid) + OCC_W'(s3_valid);

endmodule
